// File: rtl/demux_stream_if.sv
// demux_stream_if: producer-side and consumer-side stream signals of the 1-to-N demux
interface demux_stream_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT)
);
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_last;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic                   err;
  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err
  );
  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_valid, err
  );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: 1-to-N valid/ready stream demux with one holding register.
// DEMUX_PKT_LOCK_EN compiles in the packet lock that pins a packet to its first beat's channel.
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input logic clk,
  input logic rst,
  demux_stream_if.slave s
);
  logic [WIDTH-1:0]       hold_data;
  logic [SEL_W-1:0]       hold_dst;
  logic                   hold_vld;
  logic                   err_q;
  logic [SEL_W-1:0]       dest;
  logic                   first;
  logic                   legal;
  logic                   acc;
  logic [2**SEL_W-1:0]    rdy_p;
  // Pad out_ready so any select value indexes safely when N_OUT is not a power of two
  assign rdy_p      = (2**SEL_W)'(s.out_ready);
  assign legal      = {1'b0, dest} < (SEL_W+1)'(N_OUT);
  assign s.in_ready = !rst && (!hold_vld || rdy_p[hold_dst]);
  assign acc        = s.in_valid && s.in_ready;
  assign s.err      = err_q;
`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state, state_n;
  logic [SEL_W-1:0] lock_sel;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
    end else begin
      state <= state_n;
      if (acc && state == IDLE && !s.in_last) lock_sel <= s.in_sel;
    end
  always_comb begin
    state_n = state;
    if (acc) state_n = s.in_last ? IDLE : BUSY;
  end
  assign dest  = state == BUSY ? lock_sel : s.in_sel;
  assign first = state == IDLE;
`else
  assign dest  = s.in_sel;
  assign first = 1'b1;
`endif
  // An illegal lock drops the rest of its packet silently; only the first beat flags err
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      hold_dst  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= acc && !legal && first;
      if (acc) begin
        hold_vld <= legal;
        if (legal) begin
          hold_data <= s.in_data;
          hold_dst  <= dest;
        end
      end else if (hold_vld && rdy_p[hold_dst]) hold_vld <= 1'b0;
    end
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign s.out_valid[k]               = hold_vld && hold_dst == SEL_W'(k);
    assign s.out_data[k*WIDTH +: WIDTH] = s.out_valid[k] ? hold_data : '0;
  end
endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised 1-to-N stream demultiplexer with a valid/ready handshake and one registered output stage. It routes each input beat to the output channel named by `in_sel`. Channels that are not selected drive zero data, the same way the combinational demux tree behaves. It sits between a single producer and N consumers with independent back-pressure, and replaces fixed-width 1x2/1x8 demux trees wherever flow control is needed.

## Interface
Parameters:
- `WIDTH`, 8, data width per beat.
- `N_OUT`, 8, number of output channels (2..64; need not be a power of two).
- `SEL_W`, `$clog2(N_OUT)`, width of the select field.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  input beat.
- `in_sel`  in  SEL_W  destination channel.
- `in_last`  in  1  last beat of a packet (used only with `DEMUX_PKT_LOCK_EN`).
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out_data`  out  N_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  N_OUT  per-channel valid; one-hot or zero.
- `out_ready`  in  N_OUT  per-channel consumer ready.
- `err`  out  1  one-cycle pulse when a beat with `in_sel >= N_OUT` is dropped.

## Operation
- Storage is a single holding register containing `hold_data`, `hold_dst` and `hold_vld`.
- Accept condition: `acc = in_valid && in_ready`.
- Ready rule: `in_ready = !rst && (!hold_vld || out_ready[hold_dst])`. This gives pass-through when the downstream is ready and a one-beat stall when it is not.
- On `acc` with a legal destination:
  - `hold_data <= in_data`, `hold_dst <= dest`, `hold_vld <= 1`.
- On `acc` with an illegal destination (`dest >= N_OUT`):
  - The beat is consumed and discarded.
  - `hold_vld` becomes 0 unless it is refilled; `err` is 1 on the next cycle for one cycle.
- Drain: if `hold_vld && out_ready[hold_dst]` and there is no `acc`, then `hold_vld <= 0`.
- Outputs:
  - `out_valid[k] = hold_vld && (hold_dst == k)`.
  - `out_data` channel k equals `hold_data` when `out_valid[k]`, otherwise zero.
- Simultaneous drain and accept in the same cycle refills the register. There is no bubble.
- Packet state machine (only with the macro):
  - IDLE: `dest = in_sel`. On `acc` with `!in_last`, go to BUSY and latch `lock_sel <= in_sel`.
  - BUSY: `dest = lock_sel`, and `in_sel` is ignored. On `acc` with `in_last`, go to IDLE.
  - A single-beat packet (`in_last` on the first beat) stays in IDLE.
  - An illegal select on the first beat drops the whole packet. `err` pulses once for the first beat only.
- Reset, asynchronous and taking effect immediately:
  - `hold_vld = 0`, `hold_data = 0`, `hold_dst = 0`, `err = 0`, state = IDLE, `lock_sel = 0`.
  - `out_valid = 0`, `out_data = 0`, `in_ready = 0` while `rst` is high.
  - Reset mid-packet discards the held beat and the packet lock.

## Timing
- Latency: a beat accepted at edge n is visible on `out_valid` and `out_data` after edge n, i.e. in cycle n+1.
- Throughput: 1 beat/cycle while the targeted consumers keep `out_ready` high, including back-to-back beats to different channels.
- Back-pressure: `in_ready` falls in the same cycle that `hold_vld && !out_ready[hold_dst]` holds (combinational from `out_ready`). There is no combinational path from `in_valid` or `in_sel` to `in_ready`.
- The held beat remains stable until its channel's handshake completes.
- `err` is registered and asserts the cycle after the offending accept.
- The first accept is possible in the first cycle after `rst` deasserts.

## Configuration
- Macro: `DEMUX_PKT_LOCK_EN`.
- Defined: the IDLE/BUSY packet lock is compiled in. The destination is fixed from the first beat through the `in_last` beat, so packets are never split across channels.
- Undefined: there is no state machine. `dest = in_sel` on every beat, and `in_last` is ignored and unconnected internally.

## Test plan
- Reset release, then `in_sel=3`, `in_data=0xA5`, `in_valid=1`, all `out_ready=1` -> next cycle `out_valid=8'b0000_1000`, channel 3 data 0xA5, all other channels 0x00.
- Back-to-back beats to `sel=0,7,2` with all ready -> three consecutive cycles of one-hot `out_valid` at 0x01, 0x80, 0x04; `in_ready` stays 1 throughout.
- `out_ready[5]=0` while a beat for channel 5 is held -> `in_ready=0` and the data stays stable. Raising `out_ready[5]` drains the beat in 1 cycle and the next beat is accepted in the same cycle.
- `N_OUT=6`, `in_sel=6`, then `in_sel=7` -> both beats are consumed, `out_valid` stays 0, and `err` pulses for two cycles.
- With `DEMUX_PKT_LOCK_EN`: a 4-beat packet with first `in_sel=1`, then `in_sel` changing to 4 mid-packet -> all 4 beats appear on channel 1, and the next packet with `in_sel=4` goes to channel 4.
- Assert `rst` while a beat is held and the state is BUSY -> `out_valid=0`, `out_data=0` immediately. After release the state is IDLE and a new packet routes per its own `in_sel`.
